// File: rtl/ah_arb_pkg.sv
// Shared types for the AH arbiter requester agent.
//   arb_state_e : requester FSM states
//   ah_cmd_t    : queued command {id, len} at the default field widths
package ah_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OWN  = 2'd2,
    ST_REL  = 2'd3
  } arb_state_e;

  localparam int AH_ARB_ID_W     = 4;
  localparam int AH_ARB_LEN_W    = 4;
  localparam int AH_ARB_WAIT_MAX = 15;

  typedef struct packed {
    logic [AH_ARB_ID_W-1:0]  id;
    logic [AH_ARB_LEN_W-1:0] len;
  } ah_cmd_t;

endpackage

// File: rtl/ah_sync_fifo.sv
// Synchronous FIFO with show-ahead head (rdata_o is the oldest entry
// whenever empty_o is low).
//   clk, rstn        : clock, async active-low reset (flushes pointers)
//   push_i / wdata_i : write, ignored when full
//   pop_i            : read, ignored when empty
//   rdata_o          : head entry
//   full_o, empty_o  : status
module ah_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when low bits match.
  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ah_arb_requester.sv
// Requester agent for one arbiter port. Commands are queued in a FIFO;
// the head command is requested, then owned for len+1 beats, then
// released with a two-cycle req-low gap (REL + IDLE).
//   clk, rstn                   : clock, async active-low reset
//   cmd_valid/ready, cmd_id/len : command push interface
//   req, gnt                    : arbiter handshake
//   busy                        : ownership, drives arbiter gnt_busy
//   xfer_valid/id/last          : per-beat outputs
//   done                        : normal burst completion pulse
//   starve                      : waited WAIT_MAX or more cycles in REQ
//   err, err_clr                : sticky grant-loss flag and its clear
module ah_arb_requester
  import ah_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_W     = AH_ARB_ID_W,
  parameter int LEN_W    = AH_ARB_LEN_W,
  parameter int WAIT_MAX = AH_ARB_WAIT_MAX
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ID_W-1:0]  cmd_id,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             gnt,
  output logic             busy,
  output logic             xfer_valid,
  output logic [ID_W-1:0]  xfer_id,
  output logic             xfer_last,
  output logic             done,
  output logic             starve,
  output logic             err,
  input  logic             err_clr
);

  localparam int             W    = ID_W + LEN_W;
  localparam logic [15:0]    WMAX = 16'(WAIT_MAX);

  logic [W-1:0]     head;
  logic             full, empty, pop;
  logic [LEN_W-1:0] head_len;
  logic [ID_W-1:0]  head_id;

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [15:0]      wait_q, wait_d;
  logic             ok_q, ok_d;     // burst completed without grant loss
  logic             err_q, err_d;

  assign cmd_ready = !full;
  assign pop       = (state_q == ST_REL);
  assign head_id   = head[W-1:LEN_W];
  assign head_len  = head[LEN_W-1:0];

  ah_sync_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_id, cmd_len}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    ok_d    = ok_q;
    err_d   = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) state_d = ST_REQ;
      ST_REQ: begin
        if (gnt) begin
          state_d = ST_OWN;
          beat_d  = head_len;
          wait_d  = '0;
        end else if (wait_q < WMAX) begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_OWN: begin
        if (!gnt) begin
          // Grant loss aborts: the entry is dropped, no re-arbitration.
          state_d = ST_REL;
          ok_d    = 1'b0;
          err_d   = 1'b1;   // set wins over err_clr
        end else if (beat_q == '0) begin
          state_d = ST_REL;
          ok_d    = 1'b1;
        end else begin
          beat_d = beat_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ok_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // All handshake outputs decode from registers only.
  assign req        = (state_q == ST_REQ) || (state_q == ST_OWN);
  assign busy       = (state_q == ST_OWN);
  assign xfer_valid = busy && gnt;
  assign xfer_id    = busy ? head_id : '0;
  assign xfer_last  = busy && (beat_q == '0);
  assign done       = pop && ok_q;
  assign starve     = (wait_q >= WMAX);
  assign err        = err_q;

endmodule

// File: tb/tb_ah_arb_requester.sv
module tb_ah_arb_requester;

  typedef struct {
    logic [3:0] id;
    logic [3:0] len;
    bit         abort;
  } sb_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_id = '0;
  logic [3:0] cmd_len = '0;
  logic       req;
  logic       gnt = 1'b1;
  logic       busy, xfer_valid, xfer_last, done, starve, err;
  logic [3:0] xfer_id;
  logic       err_clr = 1'b0;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_done  = 0;
  bit  cur_abort = 1'b0;
  sb_t exp_q[$];

  ah_arb_requester #(.DEPTH(4), .ID_W(4), .LEN_W(4), .WAIT_MAX(15)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .req(req), .gnt(gnt), .busy(busy),
    .xfer_valid(xfer_valid), .xfer_id(xfer_id), .xfer_last(xfer_last),
    .done(done), .starve(starve), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard push on every accepted command.
  always @(posedge clk) begin
    if (rstn && cmd_valid && cmd_ready)
      exp_q.push_back('{id: cmd_id, len: cmd_len, abort: cur_abort});
  end

  // Output monitor: checks beats against the head expectation and pops
  // one entry at each release (busy falling).
  int  beats = 0, last_at = 0, nlast = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_busy = 1'b0;
      beats = 0; last_at = 0; nlast = 0;
    end else begin
      if (busy && xfer_last) nlast++;
      if (xfer_valid) begin
        beats++;
        if (xfer_last) last_at = beats;
        if (exp_q.size() > 0) chk("beat_id", xfer_id, exp_q[0].id);
        else chk("beat_sb", exp_q.size(), 1);
      end
      if (done) n_done++;
      if (prev_busy && !busy) begin
        chk("rel_sb", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          sb_t e;
          e = exp_q.pop_front();
          chk("done", done, !e.abort);
          if (!e.abort) begin
            chk("nbeats", beats, e.len + 1);
            chk("last_pos", last_at, e.len + 1);
            chk("nlast", nlast, 1);
          end
        end
        beats = 0; last_at = 0; nlast = 0;
      end else if (done) begin
        chk("done_spur", done, 0);
      end
      prev_busy = busy;
    end
  end

  task automatic push_cmd(input logic [3:0] id, input logic [3:0] len, output int waited);
    bit acc;
    waited = 0;
    cmd_valid = 1'b1; cmd_id = id; cmd_len = len;
    acc = cmd_ready;
    while (!acc && waited < 100) begin
      step();
      waited++;
      acc = cmd_ready;
    end
    chk("push_timeout", acc, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d0, act;

    // Reset state
    step(); step();
    chk("rst_req", req, 0);      chk("rst_busy", busy, 0);
    chk("rst_xv", xfer_valid, 0); chk("rst_xl", xfer_last, 0);
    chk("rst_xid", xfer_id, 0);  chk("rst_done", done, 0);
    chk("rst_starve", starve, 0); chk("rst_err", err, 0);
    chk("rst_ready", cmd_ready, 1);
    rstn = 1'b1;
    step();

    // 1: single command, exact cycle timing
    push_cmd(4'd3, 4'd2, w);                 // now in E0 cycle
    chk("t1_e0_req", req, 0);
    step(); chk("t1_e1_req", req, 1); chk("t1_e1_xv", xfer_valid, 0);
    step(); chk("t1_e2_xv", xfer_valid, 1); chk("t1_e2_id", xfer_id, 3);
            chk("t1_e2_last", xfer_last, 0); chk("t1_e2_busy", busy, 1);
    step(); chk("t1_e3_xv", xfer_valid, 1); chk("t1_e3_last", xfer_last, 0);
    step(); chk("t1_e4_xv", xfer_valid, 1); chk("t1_e4_last", xfer_last, 1);
    step(); chk("t1_e5_done", done, 1); chk("t1_e5_req", req, 0); chk("t1_e5_busy", busy, 0);
    step(); chk("t1_e6_req", req, 0); chk("t1_e6_done", done, 0);
    step(); chk("t1_e7_req", req, 0);

    // 2: five commands into a 4-deep FIFO
    d0 = n_done;
    for (int i = 1; i <= 4; i++) push_cmd(4'(i), 4'd1, w);
    chk("t2_full", cmd_ready, 0);
    push_cmd(4'd5, 4'd1, w);
    chk("t2_stall5", w, 2);
    drain();
    step(); step();
    chk("t2_ndone", n_done - d0, 5);

    // 3: starvation
    gnt = 1'b0;
    push_cmd(4'd7, 4'd0, w);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("t3_starve%0d", k), starve, (k >= 15) ? 1 : 0);
    end
    gnt = 1'b1;
    step(); chk("t3_starve_own", starve, 0); chk("t3_xv", xfer_valid, 1);
    drain(); step(); step();

    // 4: grant loss on 2nd beat
    d0 = n_done;
    cur_abort = 1'b1;
    push_cmd(4'd9, 4'd3, w);
    step(); step(); step();                  // E3: 2nd beat cycle
    gnt = 1'b0;
    #1 chk("t4_xv_sup", xfer_valid, 0); chk("t4_busy", busy, 1);
    step(); gnt = 1'b1;
    chk("t4_err", err, 1); chk("t4_done", done, 0); chk("t4_busy_rel", busy, 0);
    step(); step(); chk("t4_err_hold", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_err_clr", err, 0);
    err_clr = 1'b1;
    push_cmd(4'd10, 4'd3, w);
    step(); step(); step();
    gnt = 1'b0;
    step(); gnt = 1'b1; err_clr = 1'b0;
    chk("t4_set_wins", err, 1);
    step(); chk("t4_err_hold2", err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    cur_abort = 1'b0;
    drain();
    chk("t4_nodone", n_done - d0, 0);
    step(); step();

    // 5: async reset mid-OWN with 3 queued
    for (int i = 0; i < 4; i++) push_cmd(4'(11 + i), 4'd7, w);
    chk("t5_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("t5_req", req, 0); chk("t5_busy0", busy, 0);
    chk("t5_xv", xfer_valid, 0); chk("t5_ready", cmd_ready, 1);
    step();
    exp_q.delete();
    rstn = 1'b1;
    act = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (xfer_valid || req) act++;
    end
    chk("t5_quiet", act, 0);

    // 6: maximum length burst
    d0 = n_done;
    push_cmd(4'd5, 4'd15, w);
    drain();
    step();
    chk("t6_ndone", n_done - d0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
